// File: rtl/fcs_tx_serializer.sv
// Byte-to-bit serializer for the tag transmit path: shifts payload bytes out LSB
// first through an external bit-serial CRC-32 engine, then appends the
// complemented FCS and an idle gap.
module fcs_tx_serializer #(
    parameter int unsigned GAP_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        fcs_enable,
    output logic        fcs_s_in,
    input  logic [31:0] fcs_val,
    output logic        tx_valid,
    output logic        tx_bit,
    output logic        tx_last,
    output logic        tx_error
);

    // Keep the gap counter at least one bit wide so GAP_BITS == 0 still elaborates.
    localparam int unsigned GapW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [GapW-1:0] GapLast = (GAP_BITS > 0) ? GapW'(GAP_BITS - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StFcs,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    logic            last_q, last_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [31:0]     fcs_sr_q, fcs_sr_d;
    logic [4:0]      fcs_cnt_q, fcs_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            err_q, err_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            byte_q    <= '0;
            last_q    <= 1'b0;
            bit_idx_q <= '0;
            fcs_sr_q  <= '0;
            fcs_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            bit_idx_q <= bit_idx_d;
            fcs_sr_q  <= fcs_sr_d;
            fcs_cnt_q <= fcs_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        last_d     = last_q;
        bit_idx_d  = bit_idx_q;
        fcs_sr_d   = fcs_sr_q;
        fcs_cnt_d  = fcs_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        err_d      = 1'b0;
        in_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_bit     = 1'b0;
        tx_last    = 1'b0;
        fcs_enable = 1'b0;
        fcs_s_in   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    byte_d    = in_data;
                    last_d    = in_last;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                tx_valid   = 1'b1;
                tx_bit     = byte_q[bit_idx_q];
                fcs_enable = 1'b1;
                fcs_s_in   = byte_q[bit_idx_q];
                // Wraps to 0 after bit 7, which is what byte chaining wants.
                bit_idx_d  = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    in_ready = !last_q;
                    if (last_q) begin
                        fcs_cnt_d = '0;
                        state_d   = StFcs;
                    end else if (in_valid) begin
                        byte_d = in_data;
                        last_d = in_last;
                    end else begin
                        // Underrun: abandon the frame without an FCS.
                        err_d     = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (GAP_BITS == 0) ? StIdle : StGap;
                    end
                end
            end
            StFcs: begin
                tx_valid  = 1'b1;
                fcs_cnt_d = fcs_cnt_q + 5'd1;
                if (fcs_cnt_q == 5'd0) begin
                    // Engine clears on this edge, so grab the rest of the FCS now.
                    tx_bit   = ~fcs_val[31];
                    fcs_sr_d = {~fcs_val[30:0], 1'b0};
                end else begin
                    tx_bit   = fcs_sr_q[31];
                    fcs_sr_d = {fcs_sr_q[30:0], 1'b0};
                end
                if (fcs_cnt_q == 5'd31) begin
                    tx_last   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP_BITS == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_error = err_q;

endmodule
